// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared types for the pipelined ALU: opcode encoding and the
//             width-independent control part of the stage-1 register.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Operation select; the encoding is visible on the opcode port.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_CMP = 3'b111
    } alu_op_e;

    // Control fields captured in stage 1. The operand fields depend on WIDTH,
    // so the user wraps this struct together with a and b of its own width.
    typedef struct packed {
        alu_op_e op;
        logic    acc_en;
    } s1_ctrl_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : alu_core
//  Purpose  : Purely combinational ALU: (op_a, op_b, op) -> result + flags.
//             Result is WIDTH+1 bits; the top bit is carry, borrow or the
//             last bit shifted out, depending on the operation.
//  Revision : 1.0  initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  alu_op_e          op_i,
    output logic [WIDTH:0]   c_o,
    output logic             zero_o,
    output logic             neg_o
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]  w_a_ext;
    logic [WIDTH:0]  w_b_ext;
    logic [SH_W-1:0] w_shamt;
    logic [WIDTH:0]  w_c;

    assign w_a_ext = {1'b0, op_a_i};
    assign w_b_ext = {1'b0, op_b_i};
    // Only the low log2(WIDTH) bits of B select the shift distance.
    assign w_shamt = op_b_i[SH_W-1:0];

    // Select the result of the requested operation.
    always_comb begin
        w_c = '0;
        case (op_i)
            OP_ADD:  w_c = w_a_ext + w_b_ext;
            OP_SUB:  w_c = w_a_ext - w_b_ext;
            OP_AND:  w_c = {1'b0, op_a_i & op_b_i};
            OP_OR:   w_c = {1'b0, op_a_i | op_b_i};
            OP_XOR:  w_c = {1'b0, op_a_i ^ op_b_i};
            // Shifting the zero-extended operand leaves the last bit shifted
            // out of the data field in the carry position.
            OP_SHL:  w_c = w_a_ext << w_shamt;
            OP_SHR:  w_c = {1'b0, op_a_i >> w_shamt};
            OP_CMP:  w_c = {{WIDTH{1'b0}}, (op_a_i < op_b_i)};
            default: w_c = '0;
        endcase
    end

    assign c_o    = w_c;
    assign zero_o = (w_c[WIDTH-1:0] == '0);
    assign neg_o  = w_c[WIDTH-1];

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pipe
//  Purpose  : Two-stage valid/ready ALU pipeline. Stage 1 captures operands,
//             stage 2 computes and holds the registered result. Includes an
//             accumulator fed from the previous result and a counter of
//             completed output handshakes.
//  Revision : 1.0  initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   C,
    output logic             zero,
    output logic             neg,
    output logic [CNT_W-1:0] op_count
);

    // Stage-1 register contents: operands of this instance's width plus the
    // shared control fields.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        s1_ctrl_t         ctrl;
    } s1_t;

    s1_t              s1_q,        s1_d;
    logic             s1_valid_q,  s1_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   c_q,         c_d;
    logic             zero_q,      zero_d;
    logic             neg_q,       neg_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    logic             w_out_free;
    logic             w_advance1;
    logic             w_in_hs;
    logic             w_out_hs;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH:0]   w_core_c;
    logic             w_core_zero;
    logic             w_core_neg;

    // Accumulate mode swaps operand A for the previous result. Results reach
    // stage 2 in order, so acc_q already holds the preceding beat's result.
    assign w_op_a = s1_q.ctrl.acc_en ? acc_q : s1_q.a;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_a_i (w_op_a),
        .op_b_i (s1_q.b),
        .op_i   (s1_q.ctrl.op),
        .c_o    (w_core_c),
        .zero_o (w_core_zero),
        .neg_o  (w_core_neg)
    );

    // Handshake decode and next-state for both stages, accumulator and counter.
    always_comb begin
        w_out_free = !out_valid_q || out_ready;
        w_advance1 = s1_valid_q && w_out_free;
        in_ready   = !s1_valid_q || w_advance1;
        w_in_hs    = in_valid && in_ready;
        w_out_hs   = out_valid_q && out_ready;

        // Stage 1: reload on a new beat (even while the old one advances),
        // otherwise empty out once the held beat moves on.
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (w_in_hs) begin
            s1_d.a           = A;
            s1_d.b           = B;
            s1_d.ctrl.op     = alu_op_e'(opcode);
            s1_d.ctrl.acc_en = acc_en;
            s1_valid_d       = 1'b1;
        end else if (w_advance1) begin
            s1_valid_d = 1'b0;
        end

        // Stage 2: results only change when a new beat is loaded, so they
        // stay stable for as long as the consumer stalls.
        c_d         = c_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        out_valid_d = out_valid_q;
        if (w_advance1) begin
            c_d         = w_core_c;
            zero_d      = w_core_zero;
            neg_d       = w_core_neg;
            out_valid_d = 1'b1;
        end else if (w_out_hs) begin
            out_valid_d = 1'b0;
        end

        // A clear request wins over the update from a retiring beat.
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (w_advance1) begin
            acc_d = w_core_c[WIDTH-1:0];
        end

        cnt_d = w_out_hs ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // All pipeline state; reset drops any beat in flight immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign C         = c_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign op_count  = cnt_q;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pipe
//  Purpose  : Self-checking bench for alu_pipe (WIDTH=8, CNT_W=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  opcode;
    logic        acc_en;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  C;
    logic        zero;
    logic        neg;
    logic [15:0] op_count;

    alu_pipe #(
        .WIDTH (8),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .zero      (zero),
        .neg       (neg),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [8:0] c;
        logic       z;
        logic       n;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];

    int n_checks = 0;
    int n_pass   = 0;

    // Output handshakes seen by the monitor: {C, zero, neg} and cycle stamp.
    logic [10:0] obs[$];
    int          obs_cyc[$];
    int          cyc      = 0;
    int          hs_count = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst && out_valid && out_ready) begin
            obs.push_back({C, zero, neg});
            obs_cyc.push_back(cyc);
            hs_count++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    function automatic logic [10:0] get_obs(input int idx);
        if (idx < obs.size()) return obs[idx];
        return 11'h7FF;  // zero and neg both set: never a legal result
    endfunction

    // Reference model written in integer arithmetic.
    function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int ia, ib, sh;
        ia = int'(a);
        ib = int'(b);
        sh = int'(b[2:0]);
        case (op)
            3'd0:    return 9'(ia + ib);
            3'd1:    return 9'(ia - ib);
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return 9'(ia * (1 << sh));
            3'd6:    return 9'(ia / (1 << sh));
            default: return (ia < ib) ? 9'd1 : 9'd0;
        endcase
    endfunction

    function automatic logic [10:0] pack_res(input logic [8:0] r);
        return {r, (r[7:0] == 8'h00), r[7]};
    endfunction

    initial begin
        int          base;
        int          hs_rst;
        int          sent;
        logic        last_hs;
        logic [7:0]  macc;
        logic [8:0]  r;
        logic [10:0] exq[$];

        tbl[0]  = '{8'hF0, 8'h20, OP_ADD, 9'h110, 1'b0, 1'b0};
        tbl[1]  = '{8'h03, 8'h05, OP_SUB, 9'h1FE, 1'b0, 1'b1};
        tbl[2]  = '{8'hAA, 8'hAA, OP_XOR, 9'h000, 1'b1, 1'b0};
        tbl[3]  = '{8'h81, 8'h01, OP_SHL, 9'h102, 1'b0, 1'b0};
        tbl[4]  = '{8'h03, 8'h05, OP_CMP, 9'h001, 1'b0, 1'b0};
        tbl[5]  = '{8'h05, 8'h03, OP_CMP, 9'h000, 1'b1, 1'b0};
        tbl[6]  = '{8'hF0, 8'h3C, OP_AND, 9'h030, 1'b0, 1'b0};
        tbl[7]  = '{8'h80, 8'h01, OP_OR,  9'h081, 1'b0, 1'b1};
        tbl[8]  = '{8'hFF, 8'h0F, OP_SHL, 9'h180, 1'b0, 1'b1};
        tbl[9]  = '{8'hFF, 8'h01, OP_ADD, 9'h100, 1'b1, 1'b0};
        tbl[10] = '{8'h00, 8'h00, OP_SUB, 9'h000, 1'b1, 1'b0};
        tbl[11] = '{8'h81, 8'h03, OP_SHR, 9'h010, 1'b0, 1'b0};
        tbl[12] = '{8'h05, 8'h03, OP_SUB, 9'h002, 1'b0, 1'b0};
        tbl[13] = '{8'hF0, 8'h0B, OP_SHR, 9'h01E, 1'b0, 1'b0};

        rst = 1'b0; in_valid = 1'b0; A = '0; B = '0; opcode = '0;
        acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;

        // ---- reset / idle ----
        samp();
        check("rst out_valid", out_valid, 0);
        check("rst C/zero/neg", {C, zero, neg}, 0);
        check("rst op_count", op_count, 0);
        step(); step();
        rst = 1'b1;
        samp();
        check("idle in_ready", in_ready, 1);
        check("idle out_valid", out_valid, 0);
        check("idle C", C, 0);

        // ---- directed table, one isolated beat each ----
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            step();
            A = tbl[i].a; B = tbl[i].b; opcode = tbl[i].op; acc_en = 1'b0; in_valid = 1'b1;
            samp();
            check($sformatf("vec%0d in_ready", i), in_ready, 1);
            step();
            in_valid = 1'b0;
            samp();
            check($sformatf("vec%0d early out_valid", i), out_valid, 0);
            step();
            samp();
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d C/zero/neg", i), {C, zero, neg}, {tbl[i].c, tbl[i].z, tbl[i].n});
        end

        // ---- accumulate: clear, then four back-to-back acc beats ----
        step();
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        base = obs.size();
        for (int i = 0; i < 4; i++) begin
            A = 8'h5A; B = 8'h10; opcode = OP_ADD; acc_en = 1'b1; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0; acc_en = 1'b0;
        repeat (4) step();
        check("acc result count", obs.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("acc beat%0d", i), get_obs(base + i), {9'(16 * (i + 1)), 2'b00});
            if (i > 0 && base + i < obs_cyc.size())
                check($sformatf("acc beat%0d spacing", i), obs_cyc[base + i] - obs_cyc[base + i - 1], 1);
        end
        check("acc op_count", op_count, NV + 4);

        // ---- backpressure: two beats held, third refused ----
        out_ready = 1'b0;
        base = obs.size();
        A = 8'd1; B = 8'd1; opcode = OP_ADD; in_valid = 1'b1;
        step();
        A = 8'd2; B = 8'd2;
        step();
        A = 8'd3; B = 8'd3;
        for (int k = 0; k < 4; k++) begin
            samp();
            check($sformatf("bp%0d in_ready", k), in_ready, 0);
            check($sformatf("bp%0d out_valid", k), out_valid, 1);
            check($sformatf("bp%0d C hold", k), {C, zero, neg}, {9'h002, 2'b00});
            step();
        end
        out_ready = 1'b1;
        samp();
        check("bp release in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("bp result count", obs.size() - base, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("bp result%0d", i), get_obs(base + i), {9'(2 * (i + 1)), 2'b00});
        check("bp op_count", op_count, NV + 7);

        // ---- reset with two beats in flight ----
        A = 8'd7; B = 8'd1; opcode = OP_ADD; in_valid = 1'b1;
        step();
        A = 8'd8; B = 8'd8;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        base = obs.size();
        samp();
        check("pre-reset out_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async rst out_valid", out_valid, 0);
        check("async rst C/zero/neg", {C, zero, neg}, 0);
        check("async rst op_count", op_count, 0);
        step(); step();
        rst = 1'b1;
        out_ready = 1'b1;
        hs_rst = hs_count;
        repeat (4) step();
        check("post-rst no stale result", obs.size() - base, 0);
        check("post-rst out_valid", out_valid, 0);
        check("post-rst op_count", op_count, 0);
        A = 8'hCC; B = 8'h05; opcode = OP_ADD; acc_en = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; acc_en = 1'b0;
        step();
        samp();
        check("post-rst acc out_valid", out_valid, 1);
        check("post-rst acc cleared", {C, zero, neg}, {9'h005, 2'b00});

        // ---- random soak against the reference model ----
        macc = 8'h05;
        sent = 0;
        last_hs = 1'b0;
        step();
        base = obs.size();
        for (int c_i = 0; c_i < 20000 && sent < 1000; c_i++) begin
            if (!in_valid || last_hs) begin
                in_valid = ($urandom_range(0, 9) < 7);
                A        = 8'($urandom);
                B        = 8'($urandom);
                opcode   = 3'($urandom_range(0, 7));
                acc_en   = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            samp();
            last_hs = in_valid && in_ready;
            if (last_hs) begin
                r = ref_alu(acc_en ? macc : A, B, opcode);
                exq.push_back(pack_res(r));
                macc = r[7:0];
                sent++;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        check("soak beats sent", sent, 1000);
        check("soak result count", obs.size() - base, exq.size());
        for (int i = 0; i < exq.size(); i++)
            check($sformatf("soak result%0d", i), get_obs(base + i), exq[i]);
        check("soak op_count", op_count, 16'(hs_count - hs_rst));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_alu_pipe
`default_nettype wire
